// File: rtl/muxn_pkg.sv
// Shared types and constants for the muxn_pipe select stage.
package muxn_pkg;

    localparam int MUXN_WIDTH_DEF = 32;

    typedef enum logic [1:0] {
        EMPTY = 2'd0,
        ONE   = 2'd1,
        TWO   = 2'd2
    } muxn_state_e;

    // A single channel still needs a 1-bit select so that out-of-range values exist.
    function automatic int sel_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/muxn_comb.sv
// Purely combinational N:1 word select; out-of-range selects yield all zeros.
module muxn_comb
    import muxn_pkg::*;
#(
    parameter int N_IN  = 3,
    parameter int WIDTH = MUXN_WIDTH_DEF,
    localparam int SEL_W = sel_width(N_IN)
) (
    input  logic [N_IN*WIDTH-1:0] i_data,
    input  logic [SEL_W-1:0]      i_sel,
    output logic [WIDTH-1:0]      o_word
);

    // NOTE: o_word gets a default before the loop so no path leaves it unassigned (no latch).
    always_comb begin
        o_word = '0;
        for (int i = 0; i < N_IN; i++) begin
            if (i_sel == SEL_W'(i)) begin
                o_word = i_data[i*WIDTH +: WIDTH];
            end
        end
    end

endmodule

// File: rtl/muxn_pipe.sv
// Registered N:1 select stage with valid/ready handshake and a one-entry skid buffer.
// Optional sticky bad-select flag sel_err is enabled by defining MUXN_SELERR_EN.
module muxn_pipe
    import muxn_pkg::*;
#(
    parameter int N_IN  = 3,
    parameter int WIDTH = MUXN_WIDTH_DEF,
    localparam int SEL_W = sel_width(N_IN)
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic [N_IN*WIDTH-1:0] in_data,
    input  logic [SEL_W-1:0]      in_sel,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [WIDTH-1:0]      out_data,
    output logic [SEL_W-1:0]      out_sel
`ifdef MUXN_SELERR_EN
   ,output logic                  sel_err
`endif
);

    muxn_state_e      r_state;
    muxn_state_e      w_state_n;
    logic             r_in_ready;
    logic [WIDTH-1:0] r_m_data;
    logic [SEL_W-1:0] r_m_sel;
    logic [WIDTH-1:0] r_s_data;
    logic [SEL_W-1:0] r_s_sel;
    logic [WIDTH-1:0] w_word;
    logic             w_accept;
    logic             w_load_in;
    logic             w_load_s;
    logic             w_m_from_s;

    muxn_comb #(
        .N_IN  (N_IN),
        .WIDTH (WIDTH)
    ) u_sel (
        .i_data (in_data),
        .i_sel  (in_sel),
        .o_word (w_word)
    );

    assign w_accept = in_valid & r_in_ready;

    always_comb begin
        w_state_n  = r_state;
        w_load_in  = 1'b0;
        w_load_s   = 1'b0;
        w_m_from_s = 1'b0;
        case (r_state)
            EMPTY: begin
                if (w_accept) begin
                    w_state_n = ONE;
                    w_load_in = 1'b1;
                end
            end
            ONE: begin
                if (w_accept && out_ready) begin
                    w_load_in = 1'b1;
                end else if (w_accept) begin
                    w_state_n = TWO;
                    w_load_s  = 1'b1;
                end else if (out_ready) begin
                    w_state_n = EMPTY;
                end
            end
            TWO: begin
                if (out_ready) begin
                    w_state_n  = ONE;
                    w_m_from_s = 1'b1;
                end
            end
            default: w_state_n = EMPTY;
        endcase
    end

    // NOTE: state uses non-blocking assignments so every register samples pre-edge values.
    // NOTE: the data registers are reset too, because out_data must read zero during reset.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state    <= EMPTY;
            r_in_ready <= 1'b1;
            r_m_data   <= '0;
            r_m_sel    <= '0;
            r_s_data   <= '0;
            r_s_sel    <= '0;
        end else begin
            r_state    <= w_state_n;
            // in_ready comes from the next state, never from out_ready directly.
            r_in_ready <= (w_state_n != TWO);
            if (w_load_in) begin
                r_m_data <= w_word;
                r_m_sel  <= in_sel;
            end else if (w_m_from_s) begin
                r_m_data <= r_s_data;
                r_m_sel  <= r_s_sel;
            end
            if (w_load_s) begin
                r_s_data <= w_word;
                r_s_sel  <= in_sel;
            end
        end
    end

`ifdef MUXN_SELERR_EN
    logic r_sel_err;
    logic w_bad_sel;

    assign w_bad_sel = ({1'b0, in_sel} >= (SEL_W+1)'(N_IN));

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_sel_err <= 1'b0;
        end else if (w_accept && w_bad_sel) begin
            r_sel_err <= 1'b1;
        end
    end

    assign sel_err = r_sel_err;
`endif

    assign in_ready  = r_in_ready;
    assign out_valid = (r_state != EMPTY);
    assign out_data  = r_m_data;
    assign out_sel   = r_m_sel;

endmodule

// File: tb/tb_muxn_pipe.sv
// Self-checking bench for muxn_pipe: queue-based reference model, directed and random traffic.
`timescale 1ns/1ps
module tb_muxn_pipe;

    localparam int N = 3;
    localparam int W = 32;

    typedef struct {
        logic [W-1:0] data;
        logic [1:0]   sel;
    } beat_t;

    logic [W-1:0] ch [N] = '{32'habcdef12, 32'h12345678, 32'hbabeface};

    logic           clk = 1'b0;
    logic           rst = 1'b1;
    logic           in_valid = 1'b0;
    logic           in_ready;
    logic [N*W-1:0] in_data;
    logic [1:0]     in_sel = '0;
    logic           out_valid;
    logic           out_ready = 1'b0;
    logic [W-1:0]   out_data;
    logic [1:0]     out_sel;

    logic           u1_in_valid = 1'b0;
    logic           u1_in_ready;
    logic [W-1:0]   u1_in_data;
    logic           u1_in_sel = 1'b0;
    logic           u1_out_valid;
    logic [W-1:0]   u1_out_data;
    logic           u1_out_sel;

`ifdef MUXN_SELERR_EN
    logic sel_err;
    logic u1_sel_err;
    logic exp_err = 1'b0;
`endif

    int    n_checks = 0;
    int    n_pass   = 0;
    beat_t q[$];

    assign in_data    = {ch[2], ch[1], ch[0]};
    assign u1_in_data = ch[0];

    always #5 clk = ~clk;

    muxn_pipe #(.N_IN(N), .WIDTH(W)) dut (
`ifdef MUXN_SELERR_EN
        .sel_err   (sel_err),
`endif
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_data   (in_data),
        .in_sel    (in_sel),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data),
        .out_sel   (out_sel)
    );

    muxn_pipe #(.N_IN(1), .WIDTH(W)) dut1 (
`ifdef MUXN_SELERR_EN
        .sel_err   (u1_sel_err),
`endif
        .clk       (clk),
        .rst       (rst),
        .in_valid  (u1_in_valid),
        .in_ready  (u1_in_ready),
        .in_data   (u1_in_data),
        .in_sel    (u1_in_sel),
        .out_valid (u1_out_valid),
        .out_ready (1'b1),
        .out_data  (u1_out_data),
        .out_sel   (u1_out_sel)
    );

    task automatic check(input string tag, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, act, exp, $time);
    endtask

    function automatic logic [W-1:0] ref_word(input logic [1:0] s);
        return (int'(s) < N) ? ch[s] : '0;
    endfunction

    task automatic check_outputs();
        check("out_valid", 64'(out_valid), 64'(q.size() > 0));
        check("in_ready", 64'(in_ready), 64'(q.size() < 2));
        if (q.size() > 0) begin
            check("out_data", 64'(out_data), 64'(q[0].data));
            check("out_sel", 64'(out_sel), 64'(q[0].sel));
        end
`ifdef MUXN_SELERR_EN
        check("sel_err", 64'(sel_err), 64'(exp_err));
`endif
    endtask

    // Called at posedge+1 with inputs already driven; returns at the next posedge+1.
    task automatic tick();
        bit acc, xfer;
        beat_t b;
        @(negedge clk);
        check_outputs();
        acc  = in_valid && (q.size() < 2);
        xfer = (q.size() > 0) && out_ready;
        b.data = ref_word(in_sel);
        b.sel  = in_sel;
        @(posedge clk);
        #1;
        if (xfer) void'(q.pop_front());
        if (acc) begin
            q.push_back(b);
`ifdef MUXN_SELERR_EN
            if (int'(in_sel) >= N) exp_err = 1'b1;
`endif
        end
    endtask

    initial begin
        // Beats offered while in reset must be discarded.
        rst = 1'b1; in_valid = 1'b1; in_sel = 2'd1; out_ready = 1'b1;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("rst_out_valid", 64'(out_valid), 64'd0);
        check("rst_out_data", 64'(out_data), 64'd0);
        check("rst_out_sel", 64'(out_sel), 64'd0);
        check("rst_in_ready", 64'(in_ready), 64'd1);
        rst = 1'b0; in_valid = 1'b0;
        @(posedge clk); #1;

        // Back-to-back selects 0,1,2 with the consumer always ready.
        out_ready = 1'b1;
        for (int s = 0; s < 3; s++) begin
            in_valid = 1'b1; in_sel = 2'(s);
            tick();
        end
        in_valid = 1'b0;
        repeat (2) tick();

        // Out-of-range select, then a good beat (sticky flag).
        in_valid = 1'b1; in_sel = 2'd3; tick();
        in_sel = 2'd1; tick();
        in_valid = 1'b0; repeat (2) tick();

        // Fill the skid, hold the third beat, then drain in order.
        out_ready = 1'b0; in_valid = 1'b1;
        in_sel = 2'd0; tick();
        in_sel = 2'd1; tick();
        in_sel = 2'd2; tick(); tick();
        out_ready = 1'b1;
        for (int k = 0; k < 6; k++) begin
            bit will_acc;
            will_acc = in_valid && (q.size() < 2);
            tick();
            if (will_acc) in_valid = 1'b0;
        end
        repeat (2) tick();

        // Stall with a beat held on the output.
        in_valid = 1'b1; in_sel = 2'd2; tick();
        in_valid = 1'b0; out_ready = 1'b0;
        repeat (5) tick();
        out_ready = 1'b1; repeat (2) tick();

        // Random traffic.
        for (int k = 0; k < 300; k++) begin
            in_valid  = 1'($urandom_range(0, 1));
            in_sel    = 2'($urandom_range(0, 3));
            out_ready = ($urandom_range(0, 3) != 0);
            tick();
        end
        in_valid = 1'b0; out_ready = 1'b1; repeat (3) tick();

        // Reset asserted mid-cycle while in TWO.
        out_ready = 1'b0; in_valid = 1'b1;
        in_sel = 2'd0; tick();
        in_sel = 2'd1; tick();
        check("two_in_ready", 64'(in_ready), 64'd0);
        #3 rst = 1'b1;
        #1;
        check("arst_out_valid", 64'(out_valid), 64'd0);
        check("arst_out_data", 64'(out_data), 64'd0);
        check("arst_in_ready", 64'(in_ready), 64'd1);
`ifdef MUXN_SELERR_EN
        check("arst_sel_err", 64'(sel_err), 64'd0);
        exp_err = 1'b0;
`endif
        q.delete();
        in_valid = 1'b0;
        @(negedge clk); @(negedge clk);
        rst = 1'b0;
        @(posedge clk); #1;
        out_ready = 1'b1;
        for (int s = 0; s < 3; s++) begin
            in_valid = 1'b1; in_sel = 2'(s);
            tick();
        end
        in_valid = 1'b0;
        repeat (2) tick();

        // Single-channel instance.
        u1_in_valid = 1'b1; u1_in_sel = 1'b0;
        @(posedge clk); #1;
        u1_in_sel = 1'b1;
        @(negedge clk);
        check("n1_valid", 64'(u1_out_valid), 64'd1);
        check("n1_data0", 64'(u1_out_data), 64'(ch[0]));
        check("n1_sel0", 64'(u1_out_sel), 64'd0);
        @(posedge clk); #1;
        u1_in_valid = 1'b0;
        @(negedge clk);
        check("n1_data_bad", 64'(u1_out_data), 64'd0);
        check("n1_sel_bad", 64'(u1_out_sel), 64'd1);
`ifdef MUXN_SELERR_EN
        check("n1_sel_err", 64'(u1_sel_err), 64'd1);
`endif

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
